gf180mcu_serial_parity_checker: RTL and testbench

- Receive-side counterpart of the 3-input odd-parity generator cell.
- Deserialises a framed bitstream of DATA_W data bits (LSB first) followed by one parity bit, then checks the parity.
- Presents the word plus an error flag on a single-entry valid/ready output buffer.
- Sits between a pad-side serial input and core logic in mcu7t5v0 mixed-cell test structures.

---
 rtl/gf180mcu_parity_pkg.sv | 28 ++
 rtl/gf180mcu_skid_buf1.sv | 47 ++++
 rtl/gf180mcu_serial_parity_checker.sv | 140 ++++++++++++++
 tb/tb_gf180mcu_serial_parity_checker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_parity_pkg.sv
// gf180mcu_parity_pkg
// Shared definitions for the serial parity checker slice.
//   rx_state_t : receive FSM states (IDLE, DATA, PAR)
//   CNT_W      : bit-counter width, sized for the largest supported DATA_W
//   parity_ok  : checks running parity plus received parity bit against the
//                required odd/even sense
package gf180mcu_parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } rx_state_t;

  // The counter is shared by every DATA_W in the 2..32 range, so it is sized
  // for the maximum frame rather than per instance.
  localparam int MAX_DATA_W = 32;
  localparam int CNT_W      = $clog2(MAX_DATA_W + 1);

  // ones_parity is the XOR of all data bits; odd=1 means the data plus the
  // parity bit must contain an odd number of ones.
  function automatic logic parity_ok(input logic ones_parity,
                                     input logic par_bit,
                                     input logic odd);
    return ((ones_parity ^ par_bit) == odd);
  endfunction

endpackage

// File: rtl/gf180mcu_skid_buf1.sv
// gf180mcu_skid_buf1
// Single-entry valid/ready output register.
// Ports:
//   clk        : rising-edge clock
//   rn         : synchronous active-low reset
//   load_valid : a completed entry is offered this cycle (no backpressure)
//   load_data  : entry contents
//   buf_valid  : register holds an entry
//   buf_ready  : consumer takes the entry when buf_valid=1
//   buf_data   : held entry, stable while buf_valid=1 and buf_ready=0
//   overflow   : one-cycle pulse, an offered entry was dropped
module gf180mcu_skid_buf1 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rn,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  output logic         buf_valid,
  input  logic         buf_ready,
  output logic [W-1:0] buf_data,
  output logic         overflow
);

  // An entry is accepted when the register is empty or is being drained in
  // this same cycle, which allows back-to-back consume and refill.
  logic accept;
  assign accept = load_valid && (!buf_valid || buf_ready);

  // Dropped entries leave the held data untouched and only raise overflow.
  always_ff @(posedge clk) begin
    if (!rn) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= load_valid && !accept;
      if (accept) begin
        buf_data  <= load_data;
        buf_valid <= 1'b1;
      end else if (buf_ready) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_serial_parity_checker.sv
// gf180mcu_serial_parity_checker
// Deserialises DATA_W data bits (LSB first) plus one parity bit, checks the
// parity and presents {PERR, Q} on a single-entry valid/ready buffer.
// Optional feature macro: GF180MCU_SERIAL_PARITY_CHECKER_ERR_CNT_EN adds
// ERR_CNT, a saturating 8-bit count of completed frames with a parity error.
// Ports:
//   CLK     : rising-edge clock
//   RN      : synchronous active-low reset
//   START   : frame-start strobe; the first data bit may arrive with it
//   D       : serial data/parity bit
//   D_VALID : D is meaningful this cycle
//   Q       : received word
//   Q_VALID : output buffer full
//   Q_READY : consumer accepts Q when Q_VALID=1
//   PERR    : parity error for the word in Q
//   OVF     : one-cycle pulse, a completed frame was dropped
//   ERR_CNT : error frame count (only with the macro defined)
//   VDD/VSS : supply pins, no logical function
module gf180mcu_serial_parity_checker
  import gf180mcu_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 1
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              START,
  input  logic              D,
  input  logic              D_VALID,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  input  logic              Q_READY,
  output logic              PERR,
  output logic              OVF,
`ifdef GF180MCU_SERIAL_PARITY_CHECKER_ERR_CNT_EN
  output logic [7:0]        ERR_CNT,
`endif
  inout  wire               VDD,
  inout  wire               VSS
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  // Supply pins are carried for the cell interface only.
  wire unused_supply = VDD ^ VSS;

  rx_state_t         state_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_acc_q;

  logic              frame_done;
  logic              frame_err;
  logic [DATA_W:0]   buf_out;

  // A frame completes when the parity bit is sampled; START in the same
  // cycle aborts it instead.
  assign frame_done = (state_q == PAR) && D_VALID && !START;
  assign frame_err  = !parity_ok(par_acc_q, D, (ODD_PARITY != 0));

  // Receive FSM. START wins from any state so a partial frame is silently
  // abandoned and the new frame begins in the same cycle. Data bits are
  // OR-ed into place, which is safe because every frame start rewrites the
  // whole shift register.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      par_acc_q <= 1'b0;
    end else if (START) begin
      if (D_VALID) begin
        shift_q   <= DATA_W'(D);
        count_q   <= CNT_W'(1);
        par_acc_q <= D;
        state_q   <= (DATA_W == 1) ? PAR : DATA;
      end else begin
        shift_q   <= '0;
        count_q   <= '0;
        par_acc_q <= 1'b0;
        state_q   <= DATA;
      end
    end else begin
      case (state_q)
        DATA: begin
          if (D_VALID) begin
            shift_q   <= shift_q | (DATA_W'(D) << count_q);
            par_acc_q <= par_acc_q ^ D;
            count_q   <= count_q + 1'b1;
            if (count_q == LAST_IDX) begin
              state_q <= PAR;
            end
          end
        end
        PAR: begin
          if (D_VALID) begin
            count_q <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  gf180mcu_skid_buf1 #(
    .W (DATA_W + 1)
  ) u_out_buf (
    .clk        (CLK),
    .rn         (RN),
    .load_valid (frame_done),
    .load_data  ({frame_err, shift_q}),
    .buf_valid  (Q_VALID),
    .buf_ready  (Q_READY),
    .buf_data   (buf_out),
    .overflow   (OVF)
  );

  assign Q    = buf_out[DATA_W-1:0];
  assign PERR = buf_out[DATA_W];

`ifdef GF180MCU_SERIAL_PARITY_CHECKER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Counts every completed erroneous frame, dropped or not, so it updates
  // on the same edge as Q/OVF and sticks at 255.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      err_cnt_q <= '0;
    end else if (frame_done && frame_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_gf180mcu_serial_parity_checker.sv
// tb_gf180mcu_serial_parity_checker
// Self-checking bench: one odd-parity and one even-parity instance share the
// same stimulus. A table of frames with hand-computed error flags drives the
// main check loop; hand-written sequences cover overflow, restart, reset and
// gapped input. Define GF180MCU_SERIAL_PARITY_CHECKER_ERR_CNT_EN to also
// exercise ERR_CNT.
module tb_gf180mcu_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rn = 1'b0;
  logic       start = 1'b0;
  logic       d = 1'b0;
  logic       d_valid = 1'b0;
  logic       q_ready = 1'b1;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  logic [7:0] q_odd, q_even;
  logic       q_valid_odd, q_valid_even;
  logic       perr_odd, perr_even;
  logic       ovf_odd, ovf_even;
`ifdef GF180MCU_SERIAL_PARITY_CHECKER_ERR_CNT_EN
  logic [7:0] err_cnt_odd, err_cnt_even;
`endif

  int check_count = 0;
  int pass_count = 0;

  typedef struct {
    logic [7:0] word;
    logic       pbit;
    logic       exp_perr_odd;
    logic       exp_perr_even;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  gf180mcu_serial_parity_checker #(
    .DATA_W     (8),
    .ODD_PARITY (1)
  ) dut_odd (
    .CLK     (clk),
    .RN      (rn),
    .START   (start),
    .D       (d),
    .D_VALID (d_valid),
    .Q       (q_odd),
    .Q_VALID (q_valid_odd),
    .Q_READY (q_ready),
    .PERR    (perr_odd),
    .OVF     (ovf_odd),
`ifdef GF180MCU_SERIAL_PARITY_CHECKER_ERR_CNT_EN
    .ERR_CNT (err_cnt_odd),
`endif
    .VDD     (vdd),
    .VSS     (vss)
  );

  gf180mcu_serial_parity_checker #(
    .DATA_W     (8),
    .ODD_PARITY (0)
  ) dut_even (
    .CLK     (clk),
    .RN      (rn),
    .START   (start),
    .D       (d),
    .D_VALID (d_valid),
    .Q       (q_even),
    .Q_VALID (q_valid_even),
    .Q_READY (q_ready),
    .PERR    (perr_even),
    .OVF     (ovf_even),
`ifdef GF180MCU_SERIAL_PARITY_CHECKER_ERR_CNT_EN
    .ERR_CNT (err_cnt_even),
`endif
    .VDD     (vdd),
    .VSS     (vss)
  );

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sends nbits data bits of word LSB first, START on the first bit, with an
  // optional idle gap of (i % gap)+1 cycles after each non-final bit.
  task automatic apply_stimulus(input logic [7:0] word, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      start   = (i == 0);
      d       = word[i];
      d_valid = 1'b1;
      tick();
      start   = 1'b0;
      d_valid = 1'b0;
      if (gap > 0 && i < nbits - 1) begin
        repeat ((i % gap) + 1) tick();
      end
    end
  endtask

  task automatic send_par(input logic pbit);
    d       = pbit;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    d       = 1'b0;
  endtask

  initial begin
    // Odd: error when data+parity ones are even. Even: the opposite.
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h12, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h7E, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h01, 1'b1, 1'b1, 1'b0};

    // Reset state
    rn = 1'b0;
    repeat (2) tick();
    check_output("reset q", q_odd, 0);
    check_output("reset q_valid", q_valid_odd, 0);
    check_output("reset perr", perr_odd, 0);
    check_output("reset ovf", ovf_odd, 0);
    rn = 1'b1;
    tick();

    // Table-driven frames, consumer always ready
    q_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].word, 8, 0);
      check_output("no early q_valid", q_valid_odd, 0);
      send_par(vecs[v].pbit);
      check_output("vec q_valid", q_valid_odd, 1);
      check_output("vec q", q_odd, 32'(vecs[v].word));
      check_output("vec perr odd", perr_odd, 32'(vecs[v].exp_perr_odd));
      check_output("vec perr even", perr_even, 32'(vecs[v].exp_perr_even));
      check_output("vec q even", q_even, 32'(vecs[v].word));
      check_output("vec ovf", ovf_odd, 0);
      tick();
      check_output("vec q_valid drop", q_valid_odd, 0);
    end

    // Overflow: hold the consumer off and send two frames
    q_ready = 1'b0;
    apply_stimulus(8'h3C, 8, 0);
    send_par(1'b1);
    check_output("ovf first q_valid", q_valid_odd, 1);
    check_output("ovf first q", q_odd, 32'h3C);
    check_output("ovf first perr", perr_odd, 0);
    apply_stimulus(8'h81, 8, 0);
    check_output("ovf no early pulse", ovf_odd, 0);
    send_par(1'b1);
    check_output("ovf pulse", ovf_odd, 1);
    check_output("ovf q held", q_odd, 32'h3C);
    check_output("ovf q_valid held", q_valid_odd, 1);
    tick();
    check_output("ovf pulse ends", ovf_odd, 0);
    check_output("ovf q still held", q_odd, 32'h3C);
    q_ready = 1'b1;
    tick();
    check_output("ovf drain", q_valid_odd, 0);

    // Restart from DATA: 4 bits of 0xFF then a full 0x12 frame
    apply_stimulus(8'hFF, 4, 0);
    apply_stimulus(8'h12, 8, 0);
    check_output("restart no output", q_valid_odd, 0);
    send_par(1'b1);
    check_output("restart q_valid", q_valid_odd, 1);
    check_output("restart q", q_odd, 32'h12);
    check_output("restart perr", perr_odd, 0);
    repeat (3) tick();
    check_output("restart single output", q_valid_odd, 0);

    // Restart from PAR: 0xF0 data, then START of 0x0F instead of parity
    apply_stimulus(8'hF0, 8, 0);
    apply_stimulus(8'h0F, 8, 0);
    check_output("par restart no output", q_valid_odd, 0);
    send_par(1'b1);
    check_output("par restart q", q_odd, 32'h0F);
    check_output("par restart perr", perr_odd, 0);
    check_output("par restart ovf", ovf_odd, 0);
    tick();

    // Reset mid-frame with a word buffered
    q_ready = 1'b0;
    apply_stimulus(8'h55, 8, 0);
    send_par(1'b1);
    check_output("pre-reset buffered", q_valid_odd, 1);
    apply_stimulus(8'h0F, 3, 0);
    rn = 1'b0;
    tick();
    rn = 1'b1;
    check_output("mid reset q_valid", q_valid_odd, 0);
    check_output("mid reset q", q_odd, 0);
    q_ready = 1'b1;
    // Bits without START must be ignored after reset
    for (int i = 0; i < 9; i++) begin
      d = 1'b1;
      d_valid = 1'b1;
      tick();
    end
    d_valid = 1'b0;
    d = 1'b0;
    tick();
    check_output("post reset idle", q_valid_odd, 0);
    apply_stimulus(8'h12, 8, 0);
    send_par(1'b0);
    check_output("post reset q", q_odd, 32'h12);
    check_output("post reset perr", perr_odd, 1);
    tick();

    // Gapped input bits
    apply_stimulus(8'h5A, 8, 5);
    repeat (3) tick();
    send_par(1'b1);
    check_output("gap q_valid", q_valid_odd, 1);
    check_output("gap q", q_odd, 32'h5A);
    check_output("gap perr", perr_odd, 0);
    tick();

    // Back-to-back frames with the consumer ready
    apply_stimulus(8'h11, 8, 0);
    send_par(1'b1);
    check_output("b2b 1 q", q_odd, 32'h11);
    check_output("b2b 1 ovf", ovf_odd, 0);
    apply_stimulus(8'h22, 8, 0);
    send_par(1'b1);
    check_output("b2b 2 q", q_odd, 32'h22);
    check_output("b2b 2 ovf", ovf_odd, 0);
    apply_stimulus(8'h33, 8, 0);
    send_par(1'b0);
    check_output("b2b 3 q", q_odd, 32'h33);
    check_output("b2b 3 perr", perr_odd, 1);
    check_output("b2b 3 ovf", ovf_odd, 0);
    tick();

`ifdef GF180MCU_SERIAL_PARITY_CHECKER_ERR_CNT_EN
    // Error counter: 0x00 with parity 0 is an error for odd parity only
    rn = 1'b0;
    tick();
    rn = 1'b1;
    check_output("err_cnt reset", err_cnt_odd, 0);
    q_ready = 1'b0;
    apply_stimulus(8'h00, 8, 0);
    send_par(1'b0);
    apply_stimulus(8'h00, 8, 0);
    send_par(1'b0);
    check_output("err_cnt dropped ovf", ovf_odd, 1);
    check_output("err_cnt incl dropped", err_cnt_odd, 2);
    check_output("err_cnt even clean", err_cnt_even, 0);
    q_ready = 1'b1;
    tick();
    for (int f = 0; f < 258; f++) begin
      apply_stimulus(8'h00, 8, 0);
      send_par(1'b0);
    end
    check_output("err_cnt saturate", err_cnt_odd, 255);
    rn = 1'b0;
    tick();
    rn = 1'b1;
    check_output("err_cnt cleared", err_cnt_odd, 0);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
